// File: rtl/ped_request_unit_pkg.sv
// Shared encodings for the pedestrian request unit: FSM states and countdown width.
package ped_request_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StReq   = 2'b01,
    StClear = 2'b10,
    StCross = 2'b11
  } ped_state_e;

  localparam int unsigned CdWidth = 6;

endpackage

// File: rtl/ped_debounce.sv
// Push-button front end: 2-FF synchronizer, debounce counter and single-cycle press pulse.
module ped_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_raw_i,
  output logic press_o
);

  localparam logic [2:0] CntMax = 3'(DEBOUNCE_CYC);

  logic       sync1_q, sync2_q;
  logic [2:0] cnt_q, cnt_d;
  logic       press_q, press_d;

  // Counter saturates at CntMax so a held button fires once; only a low sample re-arms it.
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!sync2_q) begin
      cnt_d = 3'd0;
    end else if (cnt_q != CntMax) begin
      cnt_d   = cnt_q + 3'd1;
      press_d = (cnt_d == CntMax);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= 3'd0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ped_request_unit.sv
// Pedestrian request unit: latches debounced presses, drives the controller request and lamps.
// Define PED_COUNTDOWN_EN to build the crossing countdown and end-of-crossing blink.
module ped_request_unit
  import ped_request_unit_pkg::*;
#(
  parameter int unsigned TP           = 1,
  parameter int unsigned DEBOUNCE_CYC = 2,
  parameter int unsigned CROSS_TIME   = 30,
  parameter int unsigned BLINK_LAST   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_raw,
  input  logic               traff_red,
  input  logic               traff_yellow,
  input  logic               traff_green,
  input  logic               ped_green,
  output logic               btn,
  output logic               wait_lamp,
  output logic               ped_lamp,
  output logic [CdWidth-1:0] countdown,
  output logic               fault
);

  ped_state_e state_q, state_d;
  logic       press;
  logic       illegal, halt;
  logic       fault_q, btn_q, wait_q, lamp_q, lamp_d;
  logic [2:0] lamps;

  logic unused_tp;
  assign unused_tp = ^TP;

  ped_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .btn_raw_i(btn_raw),
    .press_o  (press)
  );

  assign lamps   = {traff_red, traff_yellow, traff_green};
  assign illegal = !((lamps == 3'b100) || (lamps == 3'b010) || (lamps == 3'b001)) ||
                   (ped_green != traff_red);
  // A fault seen this cycle already forces the safe outputs on the same edge it latches.
  assign halt    = fault_q | illegal;

  always_comb begin
    state_d = state_q;
    if (halt) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (press && !traff_red) state_d = StReq;
        StReq: begin
          if (traff_yellow)   state_d = StClear;
          else if (traff_red) state_d = StCross;
        end
        StClear: if (traff_red)  state_d = StCross;
        StCross: if (!traff_red) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

`ifdef PED_COUNTDOWN_EN
  localparam logic [CdWidth-1:0] CrossLoad = CdWidth'(CROSS_TIME);
  localparam logic [CdWidth-1:0] BlinkLast = CdWidth'(BLINK_LAST);

  logic [CdWidth-1:0] cd_q, cd_d;

  always_comb begin
    cd_d = '0;
    if (state_d == StCross) begin
      if (state_q != StCross) cd_d = CrossLoad;
      else if (cd_q != '0)    cd_d = cd_q - CdWidth'(1);
    end
  end

  always_comb begin
    lamp_d = 1'b0;
    if (!halt) begin
      if (state_d != StCross || cd_d > BlinkLast) lamp_d = ped_green;
      else if (cd_d != '0)                        lamp_d = ped_green & cd_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cd_q <= '0;
    else        cd_q <= cd_d;
  end

  assign countdown = cd_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{CROSS_TIME, BLINK_LAST};

  always_comb begin
    lamp_d = ped_green & !halt;
  end

  assign countdown = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      fault_q <= 1'b0;
      btn_q   <= 1'b0;
      wait_q  <= 1'b0;
      lamp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_q | illegal;
      btn_q   <= (state_d == StReq);
      wait_q  <= (state_d == StReq) || (state_d == StClear);
      lamp_q  <= lamp_d;
    end
  end

  assign btn       = btn_q;
  assign wait_lamp = wait_q;
  assign ped_lamp  = lamp_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ped_request_unit.sv
// Self-checking bench for ped_request_unit: directed table, corner sequences, random vs model.
module tb_ped_request_unit;

  localparam int DC = 2;
  localparam int CT = 30;
  localparam int BL = 5;

  localparam int MIdle  = 0;
  localparam int MReq   = 1;
  localparam int MClear = 2;
  localparam int MCross = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       traff_red = 1'b0, traff_yellow = 1'b0, traff_green = 1'b1, ped_green = 1'b0;
  logic       btn, wait_lamp, ped_lamp, fault;
  logic [5:0] countdown;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ped_request_unit #(
    .TP          (1),
    .DEBOUNCE_CYC(DC),
    .CROSS_TIME  (CT),
    .BLINK_LAST  (BL)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .traff_red   (traff_red),
    .traff_yellow(traff_yellow),
    .traff_green (traff_green),
    .ped_green   (ped_green),
    .btn         (btn),
    .wait_lamp   (wait_lamp),
    .ped_lamp    (ped_lamp),
    .countdown   (countdown),
    .fault       (fault)
  );

  // Reference model, advanced once per rising edge with the inputs present at that edge.
  int m_state = MIdle, m_cd = 0, run = 0;
  bit m_fault, m_btn, m_wait, m_lamp, m_press;
  bit raw_hist[$];

  task automatic model_edge();
    bit level, illegal;
    int ns, nlamps;
    if (!rst_n) begin
      m_state = MIdle; m_cd = 0; m_fault = 0; m_btn = 0; m_wait = 0; m_lamp = 0;
      m_press = 0; run = 0; raw_hist.delete();
      return;
    end
    nlamps  = int'(traff_red) + int'(traff_yellow) + int'(traff_green);
    illegal = (nlamps != 1) || (ped_green != traff_red);
    ns = m_state;
    if (m_fault || illegal) begin
      m_fault = 1;
      ns = MIdle;
    end else begin
      case (m_state)
        MIdle:   if (m_press && !traff_red) ns = MReq;
        MReq:    ns = traff_yellow ? MClear : (traff_red ? MCross : MReq);
        MClear:  if (traff_red) ns = MCross;
        default: if (!traff_red) ns = MIdle;
      endcase
    end
    if (ns == MCross) m_cd = (m_state != MCross) ? CT : ((m_cd > 0) ? m_cd - 1 : 0);
    else m_cd = 0;
`ifdef PED_COUNTDOWN_EN
    if (m_fault) m_lamp = 0;
    else if (ns != MCross || m_cd > BL) m_lamp = ped_green;
    else if (m_cd == 0) m_lamp = 0;
    else m_lamp = ped_green && (m_cd % 2 == 1);
`else
    m_cd = 0;
    m_lamp = ped_green && !m_fault;
`endif
    m_state = ns;
    m_btn   = (ns == MReq);
    m_wait  = (ns == MReq) || (ns == MClear);
    // Debounced level seen at this edge is the raw sample taken two edges earlier.
    level = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 1'b0;
    raw_hist.push_back(btn_raw);
    if (raw_hist.size() > 4) void'(raw_hist.pop_front());
    run = level ? run + 1 : 0;
    m_press = (run == DC);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("m_btn", int'(btn), int'(m_btn));
    chk("m_wait", int'(wait_lamp), int'(m_wait));
    chk("m_lamp", int'(ped_lamp), int'(m_lamp));
    chk("m_cd", int'(countdown), m_cd);
    chk("m_fault", int'(fault), int'(m_fault));
  endtask

  task automatic set_lamps(int ph);
    traff_green  = (ph == 0);
    traff_yellow = (ph == 1);
    traff_red    = (ph == 2);
    ped_green    = (ph == 2);
  endtask

  typedef struct {
    bit raw;
    int ph;
    bit e_btn;
    bit e_wait;
    bit e_lamp;
    int e_cd;
  } vec_t;

  vec_t tbl[11];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int cd_on, exp_cd, exp_lamp, phase, hold;
`ifdef PED_COUNTDOWN_EN
    cd_on = 1;
`else
    cd_on = 0;
`endif
    tbl[0]  = '{1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 1, 1, 0, 0};
    tbl[5]  = '{0, 0, 1, 1, 0, 0};
    tbl[6]  = '{0, 1, 0, 1, 0, 0};
    tbl[7]  = '{0, 1, 0, 1, 0, 0};
    tbl[8]  = '{0, 2, 0, 0, 1, cd_on * CT};
    tbl[9]  = '{0, 2, 0, 0, 1, cd_on * (CT - 1)};
    tbl[10] = '{0, 0, 0, 0, 0, 0};

    // Reset held with the button pressed.
    rst_n = 0; btn_raw = 1; set_lamps(0);
    repeat (3) tick();
    chk("rst_btn", int'(btn), 0);
    chk("rst_wait", int'(wait_lamp), 0);
    chk("rst_lamp", int'(ped_lamp), 0);
    chk("rst_cd", int'(countdown), 0);
    chk("rst_fault", int'(fault), 0);
    rst_n = 1;

    // Press latency, yellow handshake, crossing entry and exit.
    foreach (tbl[i]) begin
      btn_raw = tbl[i].raw;
      set_lamps(tbl[i].ph);
      tick();
      chk($sformatf("tbl%0d_btn", i), int'(btn), int'(tbl[i].e_btn));
      chk($sformatf("tbl%0d_wait", i), int'(wait_lamp), int'(tbl[i].e_wait));
      chk($sformatf("tbl%0d_lamp", i), int'(ped_lamp), int'(tbl[i].e_lamp));
      chk($sformatf("tbl%0d_cd", i), int'(countdown), tbl[i].e_cd);
      chk($sformatf("tbl%0d_fault", i), int'(fault), 0);
    end

    // One-cycle glitch must not register.
    btn_raw = 1; tick(); btn_raw = 0;
    repeat (6) begin tick(); chk("glitch_btn", int'(btn), 0); end

    // Press while the traffic light is already red is ignored.
    set_lamps(2); btn_raw = 1;
    repeat (6) begin
      tick();
      chk("red_btn", int'(btn), 0);
      chk("red_wait", int'(wait_lamp), 0);
      chk("red_lamp", int'(ped_lamp), 1);
    end
    btn_raw = 0; tick(); set_lamps(0);
    repeat (4) begin tick(); chk("red_noqueue", int'(btn), 0); end

    // Request, yellow missed, full countdown with a dropped press during the crossing.
    btn_raw = 1;
    for (int i = 0; i < 10 && !btn; i++) tick();
    chk("req_btn", int'(btn), 1);
    btn_raw = 0; set_lamps(2);
    tick();
    chk("miss_btn", int'(btn), 0);
    chk("miss_wait", int'(wait_lamp), 0);
    chk("miss_cd", int'(countdown), cd_on * CT);
    btn_raw = 1;
    for (int k = 1; k <= CT + 4; k++) begin
      if (k == 10) btn_raw = 0;
      tick();
      exp_cd = (CT - k > 0) ? CT - k : 0;
      if (!cd_on) exp_lamp = 1;
      else if (exp_cd > BL) exp_lamp = 1;
      else exp_lamp = exp_cd % 2;
      chk($sformatf("cross%0d_cd", k), int'(countdown), cd_on * exp_cd);
      chk($sformatf("cross%0d_lamp", k), int'(ped_lamp), exp_lamp);
      chk("cross_btn", int'(btn), 0);
    end
    set_lamps(0); tick();
    chk("exit_cd", int'(countdown), 0);
    chk("exit_lamp", int'(ped_lamp), 0);
    repeat (5) begin tick(); chk("exit_nopend", int'(btn), 0); end

    // Illegal lamps in REQ: sticky fault, safe outputs until reset.
    btn_raw = 1;
    for (int i = 0; i < 10 && !btn; i++) tick();
    chk("freq_btn", int'(btn), 1);
    btn_raw = 0;
    traff_red = 1; traff_green = 1; ped_green = 1;
    tick();
    chk("fault_set", int'(fault), 1);
    chk("fault_btn", int'(btn), 0);
    chk("fault_wait", int'(wait_lamp), 0);
    set_lamps(0);
    repeat (4) begin
      tick();
      chk("fault_sticky", int'(fault), 1);
      chk("fault_lamp", int'(ped_lamp), 0);
    end
    rst_n = 0; tick(); rst_n = 1;
    chk("fault_clr", int'(fault), 0);

    // Randomized legal light sequences, random button and occasional reset, vs model.
    phase = 0; hold = 3;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        if (phase == 0) phase = ($urandom_range(0, 3) == 0) ? 2 : 1;
        else if (phase == 1) phase = 2;
        else phase = 0;
        hold = (phase == 2) ? $urandom_range(1, 40) : $urandom_range(1, 8);
        set_lamps(phase);
      end
      hold--;
      if ($urandom_range(0, 3) == 0) btn_raw = ~btn_raw;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      chk_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
